// File: rtl/uart_tx_frame.sv
// UART transmitter: pops bytes from a FWFT FIFO and serialises start/data/[parity]/stop frames back-to-back.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_frame #(
    parameter int BAUD_DIV  = 5208,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 parity_odd,
    output logic                 fifo_rd_en,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] BIT_MAX  = IW'(DATA_BITS - 1);
    localparam logic          STOP_MAX = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_bitIdx;
    logic                 r_stopIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_txDone;

    logic w_bitEnd;
    logic w_frameEnd;
    logic w_pop;

`ifdef UART_TX_PARITY_EN
    logic r_parityOdd;
    logic r_parity;
`else
    logic w_unusedParity;
    assign w_unusedParity = parity_odd;
`endif

    assign w_bitEnd   = (r_cnt == CNT_MAX);
    assign w_frameEnd = (r_state == S_STOP) && w_bitEnd && (r_stopIdx == STOP_MAX);

    // Pop either from idle or in the very last stop-bit cycle so frames abut; reset blocks any pop.
    assign w_pop = !reset && !fifo_empty && ((r_state == S_IDLE) || w_frameEnd);

    assign fifo_rd_en = w_pop;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign tx_done    = r_txDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitIdx  <= '0;
            r_stopIdx <= 1'b0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_txDone  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parityOdd <= 1'b0;
            r_parity    <= 1'b0;
`endif
        end else begin
            r_txDone <= w_frameEnd;
            if (w_pop) begin
                r_state   <= S_START;
                r_cnt     <= '0;
                r_bitIdx  <= '0;
                r_stopIdx <= 1'b0;
                r_shift   <= fifo_data;
                r_txd     <= 1'b0;
                r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                r_parityOdd <= parity_odd;
                r_parity    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                    end
                    S_START: begin
                        if (w_bitEnd) begin
                            r_cnt    <= '0;
                            r_bitIdx <= '0;
                            r_state  <= S_DATA;
                            r_txd    <= r_shift[0];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    // Shift out LSB first; parity accumulates as each bit leaves the register.
                    S_DATA: begin
                        if (w_bitEnd) begin
                            r_cnt   <= '0;
                            r_shift <= r_shift >> 1;
`ifdef UART_TX_PARITY_EN
                            r_parity <= r_parity ^ r_shift[0];
`endif
                            if (r_bitIdx == BIT_MAX) begin
`ifdef UART_TX_PARITY_EN
                                r_state <= S_PARITY;
                                r_txd   <= r_parity ^ r_shift[0] ^ r_parityOdd;
`else
                                r_state   <= S_STOP;
                                r_stopIdx <= 1'b0;
                                r_txd     <= 1'b1;
`endif
                            end else begin
                                r_bitIdx <= r_bitIdx + 1'b1;
                                r_txd    <= r_shift[1];
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (w_bitEnd) begin
                            r_cnt     <= '0;
                            r_stopIdx <= 1'b0;
                            r_state   <= S_STOP;
                            r_txd     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_bitEnd) begin
                            r_cnt <= '0;
                            if (r_stopIdx == STOP_MAX) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_stopIdx <= r_stopIdx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three instances cover 8N1, 7-bit/2-stop (parity with UART_TX_PARITY_EN) and 5-bit fast baud.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int NB1 = 11;
`else
    localparam int NB1 = 10;
`endif
    localparam int F1 = 4 * NB1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       fe0, fe1, fe2;
    logic [7:0] fd0;
    logic [6:0] fd1;
    logic [4:0] fd2;
    logic       par0, par1, par2;
    logic       rd0, rd1, rd2;
    logic       txd0, txd1, txd2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    logic [7:0] q0[$];
    logic [6:0] q1[$];
    logic [4:0] q2[$];
    int pops0 = 0, pops1 = 0, pops2 = 0;
    int nPass = 0, nTotal = 0;
    int popsRef;

    logic [9:0]  seq1;
    logic [19:0] seq2;
    logic [10:0] seqP;
    logic [6:0]  seq5;

    uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .fifo_empty(fe0), .fifo_data(fd0), .parity_odd(par0),
        .fifo_rd_en(rd0), .txd(txd0), .busy(busy0), .tx_done(done0));

    uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(7), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(fe1), .fifo_data(fd1), .parity_odd(par1),
        .fifo_rd_en(rd1), .txd(txd1), .busy(busy1), .tx_done(done1));

    uart_tx_frame #(.BAUD_DIV(2), .DATA_BITS(5), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .fifo_empty(fe2), .fifo_data(fd2), .parity_odd(par2),
        .fifo_rd_en(rd2), .txd(txd2), .busy(busy2), .tx_done(done2));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // FIFO heads show junk when empty so a stray read of fifo_data is visible.
    task automatic updateFifo();
        fe0 = (q0.size() == 0);
        fd0 = fe0 ? 8'hC3 : q0[0];
        fe1 = (q1.size() == 0);
        fd1 = fe1 ? 7'h5A : q1[0];
        fe2 = (q2.size() == 0);
        fd2 = fe2 ? 5'h0A : q2[0];
    endtask

    task automatic applyStimulus();
        logic p0, p1, p2;
        @(negedge clk);
        p0 = rd0; p1 = rd1; p2 = rd2;
        @(posedge clk);
        #1;
        if (p0) begin pops0++; if (q0.size() > 0) q0.delete(0); end
        if (p1) begin pops1++; if (q1.size() > 0) q1.delete(0); end
        if (p2) begin pops2++; if (q2.size() > 0) q2.delete(0); end
        updateFifo();
        #1;
    endtask

    task automatic push0(input logic [7:0] d); q0.push_back(d); updateFifo(); #1; endtask
    task automatic push1(input logic [6:0] d); q1.push_back(d); updateFifo(); #1; endtask
    task automatic push2(input logic [4:0] d); q2.push_back(d); updateFifo(); #1; endtask

    initial begin
        reset = 1'b1;
        par0 = 1'b0; par1 = 1'b0; par2 = 1'b0;
        updateFifo();
        repeat (3) applyStimulus();
        checkOutput("reset txd0", txd0, 1);
        checkOutput("reset busy0", busy0, 0);
        checkOutput("reset rd0", rd0, 0);
        checkOutput("reset done0", done0, 0);
        checkOutput("reset txd1", txd1, 1);
        checkOutput("reset txd2", txd2, 1);
        reset = 1'b0;

        // Single 0x55 frame on 8N1
        seq1 = 10'b0101010101;
        push0(8'h55);
        checkOutput("t1 pop c0", rd0, 1);
        for (int k = 1; k <= 40; k++) begin
            applyStimulus();
            checkOutput($sformatf("t1 txd c%0d", k), txd0, seq1[9 - (k - 1) / 4]);
            checkOutput($sformatf("t1 busy c%0d", k), busy0, 1);
            checkOutput($sformatf("t1 done c%0d", k), done0, 0);
            checkOutput($sformatf("t1 rd c%0d", k), rd0, 0);
        end
        applyStimulus();
        checkOutput("t1 done c41", done0, 1);
        checkOutput("t1 busy c41", busy0, 0);
        checkOutput("t1 txd c41", txd0, 1);
        checkOutput("t1 pops", pops0, 1);

        // Back-to-back 0xA3, 0x0F
        seq2 = {10'b0110001011, 10'b0111100001};
        popsRef = pops0;
        push0(8'hA3);
        push0(8'h0F);
        checkOutput("t2 pop c0", rd0, 1);
        for (int k = 1; k <= 80; k++) begin
            applyStimulus();
            checkOutput($sformatf("t2 txd c%0d", k), txd0, seq2[19 - (k - 1) / 4]);
            checkOutput($sformatf("t2 busy c%0d", k), busy0, 1);
            checkOutput($sformatf("t2 done c%0d", k), done0, (k == 41) ? 1 : 0);
            checkOutput($sformatf("t2 rd c%0d", k), rd0, (k == 40) ? 1 : 0);
        end
        applyStimulus();
        checkOutput("t2 done c81", done0, 1);
        checkOutput("t2 busy c81", busy0, 0);
        checkOutput("t2 pops", pops0 - popsRef, 2);

        // 7-bit, 2 stop bits, 0x41 with even then odd parity
        for (int p = 0; p < 2; p++) begin
`ifdef UART_TX_PARITY_EN
            seqP = {1'b0, 7'b1000001, (p == 1), 2'b11};
`else
            seqP = {2'b00, 7'b1000001, 2'b11};
`endif
            par1 = (p == 1);
            push1(7'h41);
            checkOutput($sformatf("t3 p%0d pop", p), rd1, 1);
            for (int k = 1; k <= F1; k++) begin
                applyStimulus();
                if (k == 1) par1 = ~par1;
                checkOutput($sformatf("t3 p%0d txd c%0d", p, k), txd1, seqP[NB1 - 1 - (k - 1) / 4]);
                checkOutput($sformatf("t3 p%0d busy c%0d", p, k), busy1, 1);
                checkOutput($sformatf("t3 p%0d done c%0d", p, k), done1, 0);
            end
            applyStimulus();
            checkOutput($sformatf("t3 p%0d done end", p), done1, 1);
            checkOutput($sformatf("t3 p%0d busy end", p), busy1, 0);
        end
        checkOutput("t3 pops", pops1, 2);

        // Reset at cycle 15 of a 0xFF frame
        popsRef = pops0;
        push0(8'hFF);
        checkOutput("t4 pop c0", rd0, 1);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus();
            checkOutput($sformatf("t4 txd c%0d", k), txd0, (k <= 4) ? 0 : 1);
            checkOutput($sformatf("t4 busy c%0d", k), busy0, 1);
        end
        reset = 1'b1;
        applyStimulus();
        checkOutput("t4 txd c16", txd0, 1);
        checkOutput("t4 busy c16", busy0, 0);
        checkOutput("t4 done c16", done0, 0);
        reset = 1'b0;
        for (int k = 17; k <= 66; k++) begin
            applyStimulus();
            checkOutput($sformatf("t4 done c%0d", k), done0, 0);
            checkOutput($sformatf("t4 rd c%0d", k), rd0, 0);
            checkOutput($sformatf("t4 txd c%0d", k), txd0, 1);
        end
        checkOutput("t4 pops", pops0 - popsRef, 1);

        // Reset wins over a pending pop
        reset = 1'b1;
        push0(8'h00);
        checkOutput("t5 rd in reset", rd0, 0);
        applyStimulus();
        checkOutput("t5 rd in reset 2", rd0, 0);
        checkOutput("t5 no pop in reset", pops0 - popsRef, 1);
        reset = 1'b0;
        #1;
        checkOutput("t5 pop after reset", rd0, 1);
        for (int k = 1; k <= 41; k++) applyStimulus();
        checkOutput("t5 done c41", done0, 1);
        checkOutput("t5 pops", pops0 - popsRef, 2);

        // Empty FIFO for 100 cycles, then drop fifo_empty
        for (int k = 0; k < 100; k++) begin
            checkOutput($sformatf("t6 rd c%0d", k), rd0, 0);
            checkOutput($sformatf("t6 txd c%0d", k), txd0, 1);
            applyStimulus();
        end
        push0(8'h00);
        checkOutput("t6 pop c100", rd0, 1);
        applyStimulus();
        checkOutput("t6 txd c101", txd0, 0);
        checkOutput("t6 busy c101", busy0, 1);
        for (int k = 102; k <= 141; k++) applyStimulus();
        checkOutput("t6 done", done0, 1);

        // 5 data bits, BAUD_DIV=2, 0x13
        seq5 = 7'b0110011;
        push2(5'h13);
        checkOutput("t7 pop c0", rd2, 1);
        for (int k = 1; k <= 14; k++) begin
            applyStimulus();
            checkOutput($sformatf("t7 txd c%0d", k), txd2, seq5[6 - (k - 1) / 2]);
            checkOutput($sformatf("t7 busy c%0d", k), busy2, 1);
            checkOutput($sformatf("t7 done c%0d", k), done2, 0);
        end
        applyStimulus();
        checkOutput("t7 done c15", done2, 1);
        checkOutput("t7 busy c15", busy2, 0);
        checkOutput("t7 pops", pops2, 1);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the CPU's serial console path, replacing the fixed 8N1 / 16x-oversampled transmitter. It pops bytes from the first-word-fall-through TX FIFO with a single-cycle read strobe and serialises them LSB-first. Data width, stop-bit count and baud divisor are configurable, and consecutive frames go out back-to-back with no idle gap. It sits between the TX FIFO and the `txd` pad, in the `clk` domain.

## Interface
Parameters:
- `BAUD_DIV`, 5208 — `clk` cycles per bit (50 MHz / 9600); legal ≥ 2.
- `DATA_BITS`, 8 — data bits per frame; legal 5..9.
- `STOP_BITS`, 1 — stop bits per frame; legal 1 or 2.

Ports:
- `clk`  in  1  — clock.
- `reset`  in  1  — synchronous, active-high reset.
- `fifo_empty`  in  1  — TX FIFO empty flag.
- `fifo_data`  in  DATA_BITS  — FIFO head word; valid while `fifo_empty`=0.
- `parity_odd`  in  1  — 1 = odd parity, 0 = even; ignored without `UART_TX_PARITY_EN`.
- `fifo_rd_en`  out  1  — one-cycle pop strobe.
- `txd`  out  1  — serial line; idle high.
- `busy`  out  1  — high while a frame is on the line.
- `tx_done`  out  1  — one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE → START:
  - In IDLE with `fifo_empty`=0: assert `fifo_rd_en` for that cycle.
  - In the same cycle, latch `fifo_data` into the shift register and `parity_odd` into the parity-mode flop.
  - Enter START on the next cycle.
- Bit timing: a counter of width `$clog2(BAUD_DIV)` runs 0..BAUD_DIV-1. Every bit lasts exactly BAUD_DIV cycles. The state or bit index advances when the counter = BAUD_DIV-1.
- START: drives `txd`=0.
- DATA: drives the shift register LSB first for DATA_BITS bits. The bit index is `$clog2(DATA_BITS)` wide.
- PARITY: drives the XOR of the latched data bits, inverted when the latched `parity_odd`=1.
- STOP: drives `txd`=1 for STOP_BITS bit periods.
- STOP exit:
  - If `fifo_empty`=0 in the last cycle of the last stop bit: pop and latch in that cycle, then go to START (back-to-back).
  - Otherwise go to IDLE.
- The FIFO is never popped while `fifo_empty`=1. There is exactly one pop per frame.
- `fifo_data` changing after the pop does not affect the frame in flight.

## Timing
- Reset values: `txd`=1, `busy`=0, `fifo_rd_en`=0, `tx_done`=0, state IDLE, all counters 0.
- All outputs are registered except `fifo_rd_en`, which is combinational from state, counter and `fifo_empty`.
- Latency: pop cycle = cycle 0. `txd` falls at cycle 1.
- Frame length F = BAUD_DIV × (1 + DATA_BITS + P + STOP_BITS), where P = 1 with the macro and 0 without.
- `busy` is high on cycles 1..F.
- `tx_done` is high on cycle F+1 only. In back-to-back operation that is also the first start-bit cycle of the next frame, so `busy` stays high.
- Reset mid-frame:
  - Next cycle `txd`=1 and `busy`=0.
  - The frame is abandoned with no `tx_done` and no extra pop. The popped byte is lost.
- Reset has priority over any simultaneous pop condition: no pop occurs in a reset cycle.
- `fifo_empty` going low in a non-final cycle of STOP is ignored until the final stop cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state and one parity bit are inserted between DATA and STOP. Parity is even or odd according to the latched `parity_odd`.
- Not defined: no PARITY state, P = 0, and `parity_odd` is unused (port kept for a stable interface).

## Test plan
- BAUD_DIV=4, DATA_BITS=8, STOP_BITS=1, no parity; FIFO holds 0x55 → one `fifo_rd_en` pulse at cycle 0. `txd` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles over cycles 1..40. `tx_done` at cycle 41. `busy` low at 41.
- Same configuration, FIFO holds 0xA3 then 0x0F → second pop at cycle 40. Second start bit at 41 with no idle gap. `tx_done` at 41 and 81. Exactly 2 pops.
- With macro, DATA_BITS=7, STOP_BITS=2, 0x41: `parity_odd`=0 → parity bit 0. `parity_odd`=1 → parity bit 1. F = 4×11 = 44 cycles.
- Assert reset at cycle 15 of a 0xFF frame → `txd`=1 and `busy`=0 from cycle 16. No `tx_done`. With `fifo_empty`=1 afterwards, no further pops.
- `fifo_empty` held 1 for 100 cycles → `fifo_rd_en` never high, `txd` stays 1. Dropping `fifo_empty` at cycle 100 → pop at 100, start bit from 101.
- DATA_BITS=5, BAUD_DIV=2, 0x13 → `txd` = 0,1,1,0,0,1,1, each 2 cycles. F=14.
